// File: rtl/fpga_plb_cfg_loader.sv
// rtl/fpga_plb_cfg_loader.sv - PLB config loader: stages a word-serial frame, commits it atomically
// Optional checksum word: define FPGA_PLB_CFG_CHK_EN
module fpga_plb_cfg_loader #(
    parameter int         N_LC  = 8,
    parameter int         LUT_W = 16,
    parameter logic [7:0] MAGIC = 8'hA5
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         start_i,
    input  logic                         cfg_valid_i,
    input  logic [LUT_W-1:0]             cfg_data_i,
    output logic                         cfg_ready_o,
    output logic [N_LC-1:0][LUT_W-1:0]   plb_config_o,
    output logic                         plb_config_we_o,
    output logic                         plb_mux_sync_o,
    output logic                         plb_mux_carry_o,
    output logic                         done_o,
    output logic                         error_o
);

    localparam int IDX_W = (N_LC > 1) ? $clog2(N_LC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LC - 1);

`ifdef FPGA_PLB_CFG_CHK_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_LUT    = 3'd2,
        S_CHK    = 3'd3,
        S_COMMIT = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_LUT    = 3'd2,
        S_COMMIT = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;
`endif

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [N_LC-1:0][LUT_W-1:0]     shadow_q, shadow_d;
    logic                           sh_sync_q, sh_sync_d;
    logic                           sh_carry_q, sh_carry_d;
    logic [N_LC-1:0][LUT_W-1:0]     cfg_q, cfg_d;
    logic                           mux_sync_q, mux_sync_d;
    logic                           mux_carry_q, mux_carry_d;
    logic                           we_q, we_d;
`ifdef FPGA_PLB_CFG_CHK_EN
    logic [LUT_W-1:0]               xor_q, xor_d;
`endif

    logic rx_state;
    logic accept;
    logic magic_ok;

    // Ready depends only on being in a receive state; a restart request masks it
    always_comb begin
        rx_state = (state_q == S_HDR) || (state_q == S_LUT);
`ifdef FPGA_PLB_CFG_CHK_EN
        rx_state = rx_state || (state_q == S_CHK);
`endif
        cfg_ready_o = rx_state && !start_i;
        accept      = cfg_valid_i && cfg_ready_o;
        magic_ok    = (cfg_data_i[LUT_W-1 -: 8] == MAGIC);
    end

    // Next-state, frame staging and commit logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        sh_sync_d   = sh_sync_q;
        sh_carry_d  = sh_carry_q;
        cfg_d       = cfg_q;
        mux_sync_d  = mux_sync_q;
        mux_carry_d = mux_carry_q;
        we_d        = 1'b0;
`ifdef FPGA_PLB_CFG_CHK_EN
        xor_d       = xor_q;
`endif
        if (start_i && (rx_state || state_q == S_IDLE ||
                        state_q == S_DONE || state_q == S_ERR)) begin
            // Begin or restart: any partially staged frame is abandoned
            state_d = S_HDR;
            idx_d   = '0;
`ifdef FPGA_PLB_CFG_CHK_EN
            xor_d   = '0;
`endif
        end else begin
            case (state_q)
                S_HDR: begin
                    if (accept) begin
                        if (magic_ok) begin
                            sh_carry_d = cfg_data_i[1];
                            sh_sync_d  = cfg_data_i[0];
                            idx_d      = '0;
`ifdef FPGA_PLB_CFG_CHK_EN
                            xor_d      = cfg_data_i;
`endif
                            state_d    = S_LUT;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_LUT: begin
                    if (accept) begin
                        shadow_d[idx_q] = cfg_data_i;
`ifdef FPGA_PLB_CFG_CHK_EN
                        xor_d = xor_q ^ cfg_data_i;
`endif
                        if (idx_q == IDX_LAST) begin
`ifdef FPGA_PLB_CFG_CHK_EN
                            state_d = S_CHK;
`else
                            state_d = S_COMMIT;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
`ifdef FPGA_PLB_CFG_CHK_EN
                S_CHK: begin
                    if (accept) begin
                        state_d = (cfg_data_i == xor_q) ? S_COMMIT : S_ERR;
                    end
                end
`endif
                S_COMMIT: begin
                    // Whole frame lands on the PLB in a single edge
                    cfg_d       = shadow_q;
                    mux_sync_d  = sh_sync_q;
                    mux_carry_d = sh_carry_q;
                    we_d        = 1'b1;
                    state_d     = S_DONE;
                end
                S_IDLE, S_DONE, S_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            sh_sync_q   <= 1'b0;
            sh_carry_q  <= 1'b0;
            cfg_q       <= '0;
            mux_sync_q  <= 1'b0;
            mux_carry_q <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            sh_sync_q   <= sh_sync_d;
            sh_carry_q  <= sh_carry_d;
            cfg_q       <= cfg_d;
            mux_sync_q  <= mux_sync_d;
            mux_carry_q <= mux_carry_d;
            we_q        <= we_d;
        end
    end

`ifdef FPGA_PLB_CFG_CHK_EN
    // Running checksum over header and LUT words
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    assign plb_config_o    = cfg_q;
    assign plb_config_we_o = we_q;
    assign plb_mux_sync_o  = mux_sync_q;
    assign plb_mux_carry_o = mux_carry_q;
    assign done_o          = (state_q == S_DONE);
    assign error_o         = (state_q == S_ERR);

endmodule

// File: tb/tb_fpga_plb_cfg_loader.sv
// tb/tb_fpga_plb_cfg_loader.sv - scoreboard bench for fpga_plb_cfg_loader
module tb_fpga_plb_cfg_loader;

    localparam int N_LC  = 8;
    localparam int LUT_W = 16;

    typedef logic [N_LC-1:0][LUT_W-1:0] cfg_t;
    typedef struct {
        cfg_t cfg;
        logic sync;
        logic carry;
    } exp_t;

    logic             clk_i;
    logic             reset_ni;
    logic             start_i;
    logic             cfg_valid_i;
    logic [LUT_W-1:0] cfg_data_i;
    logic             cfg_ready_o;
    cfg_t             plb_config_o;
    logic             plb_config_we_o;
    logic             plb_mux_sync_o;
    logic             plb_mux_carry_o;
    logic             done_o;
    logic             error_o;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   we_count = 0;
    int   acc_count = 0;
    exp_t sb[$];
    cfg_t committed;

    fpga_plb_cfg_loader #(.N_LC(N_LC), .LUT_W(LUT_W), .MAGIC(8'hA5)) dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .start_i         (start_i),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_data_i      (cfg_data_i),
        .cfg_ready_o     (cfg_ready_o),
        .plb_config_o    (plb_config_o),
        .plb_config_we_o (plb_config_we_o),
        .plb_mux_sync_o  (plb_mux_sync_o),
        .plb_mux_carry_o (plb_mux_carry_o),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (plb_config_we_o) we_count = we_count + 1;
        if (cfg_valid_i && cfg_ready_o) acc_count = acc_count + 1;
    end

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic send_word(input logic [LUT_W-1:0] w, input int gap, output bit ok);
        logic rdy;
        ok = 1'b0;
        repeat (gap) @(negedge clk_i);
        @(negedge clk_i);
        cfg_valid_i = 1'b1;
        cfg_data_i  = w;
        for (int k = 0; k < 20; k++) begin
            #1 rdy = cfg_ready_o;
            @(posedge clk_i);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        #1 cfg_valid_i = 1'b0;
    endtask

    function automatic logic [LUT_W-1:0] frame_xor(input logic [LUT_W-1:0] hdr, input cfg_t w);
        logic [LUT_W-1:0] x;
        x = hdr;
        for (int i = 0; i < N_LC; i++) x = x ^ w[i];
        return x;
    endfunction

    // Sends header, LUT words and (if built in) checksum; chk_flip corrupts the checksum
    task automatic send_frame(input logic [LUT_W-1:0] hdr, input cfg_t w, input int max_gap,
                              input logic [LUT_W-1:0] chk_flip, output bit ok_all);
        bit ok;
        ok_all = 1'b1;
        send_word(hdr, (max_gap > 0) ? $urandom_range(max_gap) : 0, ok);
        ok_all &= ok;
        for (int i = 0; i < N_LC; i++) begin
            send_word(w[i], (max_gap > 0) ? $urandom_range(max_gap) : 0, ok);
            ok_all &= ok;
        end
`ifdef FPGA_PLB_CFG_CHK_EN
        send_word(frame_xor(hdr, w) ^ chk_flip, (max_gap > 0) ? $urandom_range(max_gap) : 0, ok);
        ok_all &= ok;
`else
        if (chk_flip != '0) ok_all &= 1'b1;
`endif
    endtask

    // Pops the expected commit once we_o shows up, bounded wait
    task automatic check_commit(input string name);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk_i);
            if (plb_config_we_o) seen = 1'b1;
        end
        total_cnt++;
        if (!seen || sb.size() == 0) begin
            $display("FAIL %s_commit: we_seen=%0d queued=%0d required we_seen=1 queued>=1", name, seen, sb.size());
        end else begin
            pass_cnt++;
            e = sb.pop_front();
            committed = e.cfg;
            total_cnt++;
            if (plb_config_o !== e.cfg) $display("FAIL %s_cfg: got %h required %h", name, plb_config_o, e.cfg);
            else pass_cnt++;
            total_cnt++;
            if ({plb_mux_sync_o, plb_mux_carry_o} !== {e.sync, e.carry})
                $display("FAIL %s_mux: got sync=%b carry=%b required sync=%b carry=%b", name, plb_mux_sync_o, plb_mux_carry_o, e.sync, e.carry);
            else pass_cnt++;
            total_cnt++;
            if ({done_o, error_o} !== 2'b10) $display("FAIL %s_flags: got done/err=%b%b required 10", name, done_o, error_o);
            else pass_cnt++;
            @(negedge clk_i);
            total_cnt++;
            if (plb_config_we_o !== 1'b0 || done_o !== 1'b1)
                $display("FAIL %s_we_one_cycle: got we=%b done=%b required we=0 done=1", name, plb_config_we_o, done_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; start_i = 1'b1; cfg_valid_i = 1'b1; cfg_data_i = 16'hA503;
        repeat (3) @(negedge clk_i);
        total_cnt++;
        if ({cfg_ready_o, plb_config_we_o, plb_mux_sync_o, plb_mux_carry_o, done_o, error_o} !== 6'b0 || plb_config_o !== '0)
            $display("FAIL reset_outputs: got rdy=%b we=%b s=%b c=%b d=%b e=%b cfg=%h required all 0",
                     cfg_ready_o, plb_config_we_o, plb_mux_sync_o, plb_mux_carry_o, done_o, error_o, plb_config_o);
        else pass_cnt++;
        start_i = 1'b0; cfg_valid_i = 1'b0;
        reset_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        total_cnt++;
        if (cfg_ready_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0)
            $display("FAIL reset_idle: got rdy=%b d=%b e=%b required 0 0 0", cfg_ready_o, done_o, error_o);
        else pass_cnt++;
        committed = '0;
    endtask

    task automatic test_good_frame(input int max_gap, input string name);
        cfg_t w;
        bit   ok;
        int   acc0;
        for (int i = 0; i < N_LC; i++) w[i] = LUT_W'((i + 1) * 16'h1111);
        sb.push_back('{cfg: w, sync: 1'b1, carry: 1'b1});
        pulse_start();
        acc0 = acc_count;
        send_frame(16'hA503, w, max_gap, '0, ok);
        total_cnt++;
        if (!ok) $display("FAIL %s_handshake: got ok=0 required ok=1", name);
        else pass_cnt++;
        if (max_gap == 0) begin
            // Last word accepted at edge E: COMMIT next cycle, we_o after E+1
            @(negedge clk_i);
            total_cnt++;
            if (plb_config_we_o !== 1'b0 || cfg_ready_o !== 1'b0)
                $display("FAIL %s_commit_cycle: got we=%b rdy=%b required 0 0", name, plb_config_we_o, cfg_ready_o);
            else pass_cnt++;
        end
        check_commit(name);
        total_cnt++;
        if (acc_count - acc0 !== N_LC + 1 + ((`ifdef FPGA_PLB_CFG_CHK_EN 1 `else 0 `endif)))
            $display("FAIL %s_word_count: got %0d required %0d", name, acc_count - acc0,
                     N_LC + 1 + ((`ifdef FPGA_PLB_CFG_CHK_EN 1 `else 0 `endif)));
        else pass_cnt++;
    endtask

    task automatic test_bad_magic();
        bit ok;
        int we0;
        we0 = we_count;
        pulse_start();
        send_word(16'h5A00, 0, ok);
        @(negedge clk_i);
        total_cnt++;
        if (!ok || error_o !== 1'b1 || done_o !== 1'b0 || cfg_ready_o !== 1'b0)
            $display("FAIL bad_magic_err: got ok=%b err=%b done=%b rdy=%b required 1 1 0 0", ok, error_o, done_o, cfg_ready_o);
        else pass_cnt++;
        repeat (3) @(negedge clk_i);
        total_cnt++;
        if (plb_config_o !== committed || we_count !== we0 || error_o !== 1'b1)
            $display("FAIL bad_magic_keep: got cfg=%h we_pulses=%0d err=%b required cfg=%h we_pulses=0 err=1",
                     plb_config_o, we_count - we0, error_o, committed);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        cfg_t old_w, new_w;
        bit   ok;
        int   we0, acc0;
        for (int i = 0; i < N_LC; i++) begin
            old_w[i] = LUT_W'(16'hDEAD + i);
            new_w[i] = LUT_W'(16'h0F00 + 16'h0011 * i);
        end
        we0 = we_count;
        pulse_start();
        send_word(16'hA501, 0, ok);
        for (int i = 0; i < 4; i++) send_word(old_w[i], 0, ok);
        // Word presented together with the restart must be dropped
        @(negedge clk_i);
        acc0 = acc_count;
        start_i = 1'b1; cfg_valid_i = 1'b1; cfg_data_i = 16'hBEEF;
        #1;
        total_cnt++;
        if (cfg_ready_o !== 1'b0) $display("FAIL abort_ready_masked: got rdy=%b required 0", cfg_ready_o);
        else pass_cnt++;
        @(posedge clk_i);
        #1 start_i = 1'b0; cfg_valid_i = 1'b0;
        total_cnt++;
        if (acc_count !== acc0) $display("FAIL abort_no_accept: got %0d accepted required 0", acc_count - acc0);
        else pass_cnt++;
        sb.push_back('{cfg: new_w, sync: 1'b0, carry: 1'b1});
        send_frame(16'hA502, new_w, 0, '0, ok);
        check_commit("abort");
        repeat (4) @(negedge clk_i);
        total_cnt++;
        if (we_count - we0 !== 1) $display("FAIL abort_we_pulses: got %0d required 1", we_count - we0);
        else pass_cnt++;
    endtask

    task automatic test_chk();
`ifdef FPGA_PLB_CFG_CHK_EN
        cfg_t w;
        bit   ok;
        int   we0;
        for (int i = 0; i < N_LC; i++) w[i] = LUT_W'(16'h3C00 ^ (i * 16'h0101));
        we0 = we_count;
        pulse_start();
        send_frame(16'hA500, w, 0, 16'h0001, ok);
        @(negedge clk_i);
        total_cnt++;
        if (!ok || error_o !== 1'b1 || done_o !== 1'b0)
            $display("FAIL chk_bad_err: got ok=%b err=%b done=%b required 1 1 0", ok, error_o, done_o);
        else pass_cnt++;
        repeat (3) @(negedge clk_i);
        total_cnt++;
        if (we_count !== we0 || plb_config_o !== committed)
            $display("FAIL chk_bad_keep: got we_pulses=%0d cfg=%h required 0 %h", we_count - we0, plb_config_o, committed);
        else pass_cnt++;
`else
        cfg_t w;
        bit   ok;
        int   acc0;
        for (int i = 0; i < N_LC; i++) w[i] = LUT_W'(16'hC000 + i);
        sb.push_back('{cfg: w, sync: 1'b0, carry: 1'b0});
        pulse_start();
        acc0 = acc_count;
        send_frame(16'hA5FC, w, 0, '0, ok);
        @(negedge clk_i);
        total_cnt++;
        if (!ok || acc_count - acc0 !== 9 || cfg_ready_o !== 1'b0)
            $display("FAIL nochk_nine_words: got ok=%b words=%0d rdy=%b required 1 9 0", ok, acc_count - acc0, cfg_ready_o);
        else pass_cnt++;
        check_commit("nochk");
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame(0, "good");
        test_bad_magic();
        test_abort();
        test_good_frame(3, "throttled");
        test_chk();
        total_cnt++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

endmodule
